// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: registered, glitch-free clock_out plus period tick,
// with ratio changes deferred to period wrap. Optional macro CLK_DIV_CTRL_SWCNT_EN adds sw_cnt.
module clk_div_ctrl #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic         clock_in,
    input  logic         reset_n,
    input  logic         en,
    input  logic         req_valid,
    input  logic [W-1:0] req_div,
    output logic         req_ready,
    output logic         req_err,
    output logic         clock_out,
    output logic         tick,
    output logic [W-1:0] cur_div,
    output logic         busy
`ifdef CLK_DIV_CTRL_SWCNT_EN
    ,
    output logic [7:0]   sw_cnt
`endif
);

    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
    localparam logic [W-1:0] MIN_DIV_W = W'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_cur_div;
    logic [W-1:0]   r_pend_div;
    logic           r_clock_out;
    logic           r_tick;
    logic           r_busy;
    logic           r_req_err;
    logic           r_req_ready;

    logic [W-1:0]   w_cnt_nxt;
    logic [W-1:0]   w_cur_div_nxt;
    logic [W-1:0]   w_pend_div_nxt;
    logic           w_clock_out_nxt;
    logic           w_tick_nxt;
    logic           w_busy_nxt;
    logic           w_req_err_nxt;
    logic           w_req_ready_nxt;
    logic           w_applied;
    logic           w_active_nxt;

    logic           w_accept;
    logic           w_legal;
    logic           w_accept_ok;
    logic           w_last;
    logic [W-1:0]   w_cnt_inc;

    assign w_accept    = req_valid && r_req_ready;
    assign w_legal     = (req_div >= MIN_DIV_W);
    assign w_accept_ok = w_accept && w_legal;
    assign w_last      = (r_cnt == (r_cur_div - W'(1)));
    assign w_cnt_inc   = w_last ? '0 : (r_cnt + W'(1));

    // State register
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: disabling always finishes the running period before IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = w_last ? IDLE : DRAIN;
                end else if (w_accept_ok) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    w_state_nxt = w_last ? IDLE : DRAIN;
                end else if (w_last) begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; a new ratio only ever lands at a period boundary
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_cur_div_nxt   = r_cur_div;
        w_pend_div_nxt  = r_pend_div;
        w_busy_nxt      = r_busy;
        w_applied       = 1'b0;
        w_req_err_nxt   = w_accept && !w_legal;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept_ok) begin
                    w_cur_div_nxt = req_div;
                    w_applied     = 1'b1;
                end
            end
            RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_accept_ok) begin
                    if (w_state_nxt == IDLE) begin
                        w_cur_div_nxt = req_div;
                        w_applied     = 1'b1;
                    end else begin
                        w_pend_div_nxt = req_div;
                        w_busy_nxt     = 1'b1;
                    end
                end
            end
            PEND, DRAIN: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_last && r_busy) begin
                    w_cur_div_nxt = r_pend_div;
                    w_busy_nxt    = 1'b0;
                    w_applied     = 1'b1;
                end
            end
            default: w_cnt_nxt = '0;
        endcase

        if (w_state_nxt == IDLE) begin
            w_cnt_nxt = '0;
        end

        w_active_nxt    = (w_state_nxt != IDLE);
        w_clock_out_nxt = w_active_nxt && (w_cnt_nxt < (w_cur_div_nxt >> 1));
        w_tick_nxt      = w_active_nxt && (w_cnt_nxt == '0);
        w_req_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == RUN);
    end

    // Datapath and output registers
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_cur_div   <= DEF_DIV_W;
            r_pend_div  <= DEF_DIV_W;
            r_clock_out <= 1'b0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_req_err   <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_cur_div   <= w_cur_div_nxt;
            r_pend_div  <= w_pend_div_nxt;
            r_clock_out <= w_clock_out_nxt;
            r_tick      <= w_tick_nxt;
            r_busy      <= w_busy_nxt;
            r_req_err   <= w_req_err_nxt;
            r_req_ready <= w_req_ready_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign req_err   = r_req_err;
    assign clock_out = r_clock_out;
    assign tick      = r_tick;
    assign cur_div   = r_cur_div;
    assign busy      = r_busy;

`ifdef CLK_DIV_CTRL_SWCNT_EN
    logic [7:0] r_sw_cnt;

    // Saturating count of applied ratio changes
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_cnt <= 8'd0;
        end else if (w_applied && (r_sw_cnt != 8'hFF)) begin
            r_sw_cnt <= r_sw_cnt + 8'd1;
        end
    end

    assign sw_cnt = r_sw_cnt;
`else
    logic w_unused_applied;
    assign w_unused_applied = w_applied;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed, table-driven bench for clk_div_ctrl (default W=8, DEF_DIV=4),
// plus hand sequences for reset-in-PEND, the 255 boundary and the optional sw_cnt.
module tb_clk_div_ctrl;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       en;
    logic       req_valid;
    logic [7:0] req_div;
    logic       req_ready;
    logic       req_err;
    logic       clock_out;
    logic       tick;
    logic [7:0] cur_div;
    logic       busy;
`ifdef CLK_DIV_CTRL_SWCNT_EN
    logic [7:0] sw_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(.W(8), .DEF_DIV(4)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .en        (en),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .req_err   (req_err),
        .clock_out (clock_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .busy      (busy)
`ifdef CLK_DIV_CTRL_SWCNT_EN
        ,
        .sw_cnt    (sw_cnt)
`endif
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int en;
        int rv;
        int rd;
        int co;
        int tk;
        int bs;
        int rdy;
        int er;
        int dv;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input int e, input int rv, input int rd, input int co,
                                input int tk, input int bs, input int rdy, input int er,
                                input int dv);
        vec_t v;
        v.en = e; v.rv = rv; v.rd = rd; v.co = co; v.tk = tk;
        v.bs = bs; v.rdy = rdy; v.er = er; v.dv = dv;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " clock_out"}, 32'(clock_out), 0);
        chk({tag, " tick"},      32'(tick),      0);
        chk({tag, " busy"},      32'(busy),      0);
        chk({tag, " req_err"},   32'(req_err),   0);
        chk({tag, " req_ready"}, 32'(req_ready), 1);
        chk({tag, " cur_div"},   32'(cur_div),   4);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clock_in);
        @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi;
        int   n;
        int   pat [8];

        reset_n   = 1'b0;
        en        = 1'b0;
        req_valid = 1'b0;
        req_div   = 8'd0;

        // en, rv, rd | clock_out, tick, busy, req_ready, req_err, cur_div (after the edge)
        add(1,0,0, 1,1,0,1,0,4);
        add(1,0,0, 1,0,0,1,0,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 1,1,0,1,0,4);
        add(1,0,0, 1,0,0,1,0,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 1,1,0,1,0,4);
        add(1,0,0, 1,0,0,1,0,4);
        add(1,1,6, 0,0,1,0,0,4);
        add(1,0,0, 0,0,1,0,0,4);
        add(1,0,0, 1,1,0,1,0,6);
        add(1,0,0, 1,0,0,1,0,6);
        add(1,0,0, 1,0,0,1,0,6);
        add(1,0,0, 0,0,0,1,0,6);
        add(1,0,0, 0,0,0,1,0,6);
        add(1,0,0, 0,0,0,1,0,6);
        add(1,0,0, 1,1,0,1,0,6);
        add(1,1,4, 1,0,1,0,0,6);
        add(1,0,0, 1,0,1,0,0,6);
        add(1,0,0, 0,0,1,0,0,6);
        add(1,0,0, 0,0,1,0,0,6);
        add(1,0,0, 0,0,1,0,0,6);
        add(1,0,0, 1,1,0,1,0,4);
        add(1,0,0, 1,0,0,1,0,4);
        add(1,1,1, 0,0,0,1,1,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 1,1,0,1,0,4);
        add(1,1,0, 1,0,0,1,1,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 0,0,0,1,0,4);
        add(1,0,0, 1,1,0,1,0,4);
        add(1,1,5, 1,0,1,0,0,4);
        add(1,0,0, 0,0,1,0,0,4);
        add(1,0,0, 0,0,1,0,0,4);
        add(1,0,0, 1,1,0,1,0,5);
        add(0,0,0, 1,0,0,0,0,5);
        add(0,0,0, 0,0,0,0,0,5);
        add(0,0,0, 0,0,0,0,0,5);
        add(1,0,0, 0,0,0,0,0,5);
        add(1,0,0, 0,0,0,1,0,5);
        add(1,0,0, 1,1,0,1,0,5);
        add(1,0,0, 1,0,0,1,0,5);
        add(1,0,0, 0,0,0,1,0,5);
        add(0,0,0, 0,0,0,0,0,5);
        add(0,0,0, 0,0,0,0,0,5);
        add(0,0,0, 0,0,0,1,0,5);
        add(0,0,0, 0,0,0,1,0,5);
        add(0,1,3, 0,0,0,1,0,3);
        add(1,0,0, 1,1,0,1,0,3);
        add(1,0,0, 0,0,0,1,0,3);
        add(1,0,0, 0,0,0,1,0,3);
        add(1,0,0, 1,1,0,1,0,3);

        #12;
        chk_reset_vals("reset");
        @(negedge clock_in);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            en        = vq[i].en[0];
            req_valid = vq[i].rv[0];
            req_div   = 8'(vq[i].rd);
            @(posedge clock_in);
            #1;
            chk($sformatf("vec%0d clock_out", i), 32'(clock_out), vq[i].co);
            chk($sformatf("vec%0d tick", i),      32'(tick),      vq[i].tk);
            chk($sformatf("vec%0d busy", i),      32'(busy),      vq[i].bs);
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready), vq[i].rdy);
            chk($sformatf("vec%0d req_err", i),   32'(req_err),   vq[i].er);
            chk($sformatf("vec%0d cur_div", i),   32'(cur_div),   vq[i].dv);
        end

        // Reset while a ratio change is pending: cleared at once, ratio never applied
        en        = 1'b1;
        req_valid = 1'b1;
        req_div   = 8'd7;
        @(posedge clock_in);
        #1;
        req_valid = 1'b0;
        req_div   = 8'd0;
        chk("pend busy", 32'(busy), 1);
        chk("pend cur_div", 32'(cur_div), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        @(negedge clock_in);
        reset_n = 1'b1;
        @(posedge clock_in);
        #1;
        chk("restart clock_out", 32'(clock_out), 1);
        chk("restart tick", 32'(tick), 1);
        pat = '{1, 0, 0, 1, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            @(posedge clock_in);
            #1;
            chk($sformatf("post-reset clock_out %0d", i), 32'(clock_out), pat[i]);
            chk($sformatf("post-reset tick %0d", i), 32'(tick), (i == 3 || i == 7) ? 1 : 0);
            chk($sformatf("post-reset cur_div %0d", i), 32'(cur_div), 4);
        end

        // Largest ratio: period 255 cycles, 127 high, counter must not overflow
        en = 1'b0;
        pulse_reset();
        req_valid = 1'b1;
        req_div   = 8'd255;
        @(posedge clock_in);
        #1;
        chk("max load cur_div", 32'(cur_div), 255);
        req_valid = 1'b0;
        en        = 1'b1;
        @(posedge clock_in);
        #1;
        chk("max first tick", 32'(tick), 1);
        hi = 1;
        n  = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clock_in);
            #1;
            n++;
            if (tick) break;
            if (clock_out) hi++;
        end
        chk("max period", n, 255);
        chk("max high time", hi, 127);

`ifdef CLK_DIV_CTRL_SWCNT_EN
        en = 1'b0;
        pulse_reset();
        chk("sw_cnt reset", 32'(sw_cnt), 0);
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'b1;
            req_div   = (i % 2 == 0) ? 8'd2 : 8'd3;
            @(posedge clock_in);
            #1;
            if (i == 0) chk("sw_cnt first", 32'(sw_cnt), 1);
        end
        req_valid = 1'b0;
        chk("sw_cnt saturate", 32'(sw_cnt), 255);
        chk("sw_cnt last div", 32'(cur_div), 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the width of the divide ratio.
REQ-002 The module SHALL have parameter DEF_DIV, default 4, giving the ratio loaded at reset; legal range 2..2^W-1.
REQ-003 The module SHALL have port clock_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit: run request for the divided clock.
REQ-006 The module SHALL have port req_valid, input, 1 bit: a new-ratio request is present.
REQ-007 The module SHALL have port req_div, input, W bits: the requested ratio.
REQ-008 The module SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-009 The module SHALL have port req_err, output, 1 bit: one-cycle pulse when an accepted ratio is illegal.
REQ-010 The module SHALL have port clock_out, output, 1 bit: the registered, glitch-free divided clock.
REQ-011 The module SHALL have port tick, output, 1 bit: one-cycle pulse at each clock_out period start.
REQ-012 The module SHALL have port cur_div, output, W bits: the ratio currently in effect.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a ratio change is pending.

Function
REQ-014 The module SHALL use states IDLE, RUN, PEND and DRAIN, held in a phase counter cnt of W bits running 0..cur_div-1 that wraps to 0.
REQ-015 In RUN/PEND, clock_out SHALL be high for cnt in 0..floor(cur_div/2)-1 and low otherwise, so the period is cur_div cycles and the high time is floor(cur_div/2).
REQ-016 tick SHALL be high in exactly the cycle where cnt==0 with clock_out rising, which is one pulse per period.
REQ-017 IDLE with en=1 SHALL go to RUN, with cnt=0 and clock_out=1 in the first following cycle.
REQ-018 A request SHALL be accepted when req_valid&&req_ready; req_ready SHALL be 1 in IDLE and RUN and 0 in PEND and DRAIN.
REQ-019 An accepted req_div of 0 or 1 SHALL be discarded: req_err pulses 1 cycle after acceptance, state and cur_div are unchanged.
REQ-020 An accepted legal ratio in IDLE SHALL load cur_div on the next cycle.
REQ-021 An accepted legal ratio in RUN SHALL be latched, with busy=1 and a move to PEND.
REQ-022 In PEND, when cnt==cur_div-1, cur_div SHALL take the latched ratio, cnt SHALL wrap to 0, busy SHALL clear and the state SHALL return to RUN, so no period ever mixes ratios.
REQ-023 en falling in RUN SHALL move the state to DRAIN, and en falling in PEND SHALL also move it to DRAIN with the pending ratio kept.
REQ-024 DRAIN SHALL finish the current period; at cnt==cur_div-1 it SHALL apply any pending ratio, force clock_out=0, clear busy and go to IDLE.
REQ-025 en rising during DRAIN SHALL be ignored until IDLE is reached; restart then follows REQ-017.
REQ-026 In IDLE, clock_out SHALL be 0, tick SHALL be 0 and cnt SHALL be 0.
REQ-027 A shrinking ratio SHALL never truncate the current period, because the change is applied only at wrap (REQ-022).
REQ-028 When cur_div==2^W-1, cnt SHALL reach 2^W-2 and wrap with no overflow.

Reset
REQ-029 While reset_n=0, the module SHALL asynchronously force state=IDLE, cnt=0, cur_div=DEF_DIV, clock_out=0, tick=0, busy=0, req_err=0 and req_ready=1.
REQ-030 Reset asserted mid-period SHALL discard any pending ratio; operation after release follows REQ-017.

Configuration
REQ-031 With macro CLK_DIV_CTRL_SWCNT_EN defined, the module SHALL add output sw_cnt (8 bits): an increment on each applied legal ratio change, saturating at 255 and cleared by reset.
REQ-032 With CLK_DIV_CTRL_SWCNT_EN undefined, the sw_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL check: reset, then en=1 with DEF_DIV=4 -> clock_out pattern 1,1,0,0 repeats and tick fires every 4 cycles.
REQ-034 The bench SHALL check: in RUN at div 4, request 6 at cnt=1 -> busy=1, the current period stays at 4 cycles, then 3-high/3-low periods follow and cur_div=6.
REQ-035 The bench SHALL check: a request with req_div=1 -> req_err pulses once, cur_div stays 4 and the period is unchanged.
REQ-036 The bench SHALL check: en dropped at cnt=0 with div 5 -> 5 more cycles complete (2 high, 3 low), then clock_out=0 in IDLE and req_ready=1.
REQ-037 The bench SHALL check: reset_n pulsed low while in PEND -> outputs take their reset values immediately and the pending ratio is never applied.
REQ-038 The bench SHALL check: with CLK_DIV_CTRL_SWCNT_EN defined, 300 legal changes -> sw_cnt=255.
